// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: walks the layer descriptor stream and drives the conv, pool and FC engines.
module cnn_layer_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int MAX_K  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        layer_idx,
   output logic [DATA_W-1:0] cfg_ksize,
   output logic [DATA_W-1:0] cfg_nkern,
   output logic [DATA_W-1:0] cfg_nbias,
   output logic [ADDR_W-1:0] cfg_bias_base,
   output logic [ADDR_W-1:0] cfg_wgt_base,
   output logic              conv_start,
   input  logic              conv_done,
   output logic              pool_start,
   input  logic              pool_done,
   output logic              fc_start,
   input  logic              fc_done
);
   localparam int W = 3 * DATA_W + 2;
   typedef enum logic [3:0] {
      IDLE, RD_CNT, RD_TYPE, RD_K, RD_N, RD_B, CALC, CONV_GO, CONV_WAIT,
      POOL_GO, POOL_WAIT, FC_GO, FC_WAIT, FIN, ERR
   } state_t;
   state_t state;
   logic ph;
   logic [DATA_W-1:0] cnt, k_r, n_r, b_r;
   logic [ADDR_W-1:0] hdr;
   logic [W-1:0] bias_w, wgt_w, next_w;
   logic last, bad_hdr, eng_done;
   // wide enough that no descriptor can wrap before the range check
   always_comb begin
      bias_w = W'(hdr) + W'(4);
      wgt_w  = bias_w + W'(b_r);
      next_w = wgt_w + W'(n_r) * W'(k_r) * W'(k_r);
   end
   assign last     = (DATA_W'(layer_idx) + DATA_W'(1)) == cnt;
   assign bad_hdr  = (k_r == '0) || (k_r > DATA_W'(MAX_K)) || (n_r == '0);
   assign eng_done = (state == CONV_WAIT) ? conv_done : pool_done;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ph            <= 1'b0;
         cnt           <= '0;
         k_r           <= '0;
         n_r           <= '0;
         b_r           <= '0;
         hdr           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         mem_rd        <= 1'b0;
         mem_addr      <= '0;
         layer_idx     <= '0;
         cfg_ksize     <= '0;
         cfg_nkern     <= '0;
         cfg_nbias     <= '0;
         cfg_bias_base <= '0;
         cfg_wgt_base  <= '0;
         conv_start    <= 1'b0;
         pool_start    <= 1'b0;
         fc_start      <= 1'b0;
      end else begin
         mem_rd     <= 1'b0;
         conv_start <= 1'b0;
         pool_start <= 1'b0;
         fc_start   <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE, ERR: if (start) begin
               state     <= RD_CNT;
               ph        <= 1'b0;
               mem_rd    <= 1'b1;
               mem_addr  <= '0;
               layer_idx <= '0;
               busy      <= 1'b1;
               error     <= 1'b0;
            end
            // mem_addr doubles as the descriptor pointer; ph splits issue/capture
            RD_CNT, RD_TYPE, RD_K, RD_N, RD_B: if (!ph) ph <= 1'b1;
            else begin
               ph       <= 1'b0;
               mem_addr <= mem_addr + ADDR_W'(1);
               case (state)
                  RD_CNT: begin
                     cnt <= mem_rdata;
                     if (mem_rdata == '0) begin
                        state    <= FC_GO;
                        fc_start <= 1'b1;
                     end else begin
                        state  <= RD_TYPE;
                        mem_rd <= 1'b1;
                     end
                  end
                  RD_TYPE: begin
                     hdr <= mem_addr;
                     if (mem_rdata == DATA_W'(0)) begin
                        state  <= RD_K;
                        mem_rd <= 1'b1;
                     end else if (mem_rdata == DATA_W'(1)) begin
                        state      <= POOL_GO;
                        pool_start <= 1'b1;
                     end else begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                     end
                  end
                  RD_K: begin
                     k_r    <= mem_rdata;
                     state  <= RD_N;
                     mem_rd <= 1'b1;
                  end
                  RD_N: begin
                     n_r    <= mem_rdata;
                     state  <= RD_B;
                     mem_rd <= 1'b1;
                  end
                  default: begin
                     b_r   <= mem_rdata;
                     state <= bad_hdr ? ERR : CALC;
                     busy  <= !bad_hdr;
                     error <= bad_hdr;
                  end
               endcase
            end
            CALC: if (|next_w[W-1:ADDR_W]) begin
               state <= ERR;
               busy  <= 1'b0;
               error <= 1'b1;
            end else begin
               cfg_ksize     <= k_r;
               cfg_nkern     <= n_r;
               cfg_nbias     <= b_r;
               cfg_bias_base <= bias_w[ADDR_W-1:0];
               cfg_wgt_base  <= wgt_w[ADDR_W-1:0];
               mem_addr      <= next_w[ADDR_W-1:0];
               state         <= CONV_GO;
               conv_start    <= 1'b1;
            end
            CONV_GO: state <= CONV_WAIT;
            POOL_GO: state <= POOL_WAIT;
            FC_GO:   state <= FC_WAIT;
            CONV_WAIT, POOL_WAIT: if (eng_done) begin
               layer_idx <= layer_idx + 8'd1;
               if (last) begin
                  state    <= FC_GO;
                  fc_start <= 1'b1;
               end else begin
                  state  <= RD_TYPE;
                  mem_rd <= 1'b1;
               end
            end
            FC_WAIT: if (fc_done) begin
               state <= FIN;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: scoreboard bench with descriptor memory and auto-responding engines.
module tb_cnn_layer_sequencer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic busy, done, error, mem_rd;
   logic [15:0] mem_addr, mem_rdata;
   logic [7:0] layer_idx;
   logic [15:0] cfg_ksize, cfg_nkern, cfg_nbias, cfg_bias_base, cfg_wgt_base;
   logic conv_start, pool_start, fc_start;
   logic conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0;
   cnn_layer_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .layer_idx(layer_idx),
      .cfg_ksize(cfg_ksize), .cfg_nkern(cfg_nkern), .cfg_nbias(cfg_nbias),
      .cfg_bias_base(cfg_bias_base), .cfg_wgt_base(cfg_wgt_base),
      .conv_start(conv_start), .conv_done(conv_done), .pool_start(pool_start),
      .pool_done(pool_done), .fc_start(fc_start), .fc_done(fc_done)
   );
   always #5 clk = ~clk;
   localparam int K_RD = 0, K_CONV = 1, K_POOL = 2, K_FC = 3, K_DONE = 4;
   typedef struct { int kind; longint val; int at; } ev_t;
   ev_t q[$];
   logic [15:0] mem [0:255];
   int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0;
   int cd = 0, pd = 0, fd = 0;
   logic eng_conv = 1'b1, force_cd = 1'b0;
   logic any_out;
   assign any_out = |{busy, done, error, mem_rd, mem_addr, layer_idx, cfg_ksize, cfg_nkern,
                      cfg_nbias, cfg_bias_base, cfg_wgt_base, conv_start, pool_start, fc_start};
   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic expect_ev(input int kind, input longint val, input int at);
      ev_t e;
      e.kind = kind; e.val = val; e.at = at;
      q.push_back(e);
   endtask
   task automatic pop_ev(input int kind, input longint val, input int rel);
      ev_t e;
      if (q.size() == 0) begin
         check("unexpected_event", kind, -1);
         return;
      end
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
      if (e.at >= 0) check("event_cycle", rel, e.at);
   endtask
   function automatic longint conv_val(int idx, int k, int n, int b, int w);
      return (longint'(idx) << 48) | (longint'(k) << 40) | (longint'(n) << 32) |
             (longint'(b) << 16) | longint'(w);
   endfunction
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
   end
   // monitor pops the scoreboard, then the engine models respond
   always @(negedge clk) begin
      int rel, n;
      rel = cyc - t0;
      n = int'(conv_start) + int'(pool_start) + int'(fc_start) + int'(done);
      if (n != 0) check("pulse_overlap", n, 1);
      if (mem_rd) pop_ev(K_RD, longint'(mem_addr), rel);
      if (conv_start) pop_ev(K_CONV, conv_val(layer_idx, cfg_ksize[7:0], cfg_nkern[7:0],
                                              cfg_bias_base, cfg_wgt_base), rel);
      if (pool_start) pop_ev(K_POOL, longint'(layer_idx), rel);
      if (fc_start) pop_ev(K_FC, 0, rel);
      if (done) pop_ev(K_DONE, 0, rel);
      conv_done = force_cd;
      if (cd != 0) begin cd--; if (cd == 0) conv_done = 1'b1; end
      if (conv_start && eng_conv) cd = 3;
      pool_done = 1'b0;
      if (pd != 0) begin pd--; if (pd == 0) pool_done = 1'b1; end
      if (pool_start) pd = 3;
      fc_done = 1'b0;
      if (fd != 0) begin fd--; if (fd == 0) fc_done = 1'b1; end
      if (fc_start) fd = 2;
   end
   task automatic clr();
      for (int i = 0; i < 256; i++) mem[i] = 16'd0;
   endtask
   task automatic run(input int restart_at, input logic exp_err);
      logic fin;
      fin = 1'b0;
      t0 = cyc;
      start = 1'b1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         start = (i == restart_at);
         if (i == 1) begin
            check("busy_after_start", busy, 1);
            check("error_cleared", error, 0);
         end
         if (done || error) begin fin = 1'b1; break; end
      end
      start = 1'b0;
      if (!fin) check("run_timeout", 0, 1);
      @(negedge clk);
      check("sb_drained", q.size(), 0);
      check("error_end", error, exp_err);
      check("busy_end", busy, 0);
      q.delete();
   endtask
   initial begin
      clr();
      repeat (2) @(negedge clk);
      check("reset_outputs", any_out, 0);
      rst = 1'b0;
      @(negedge clk);
      // single pool layer, cycle-exact
      mem[0] = 1; mem[1] = 1;
      expect_ev(K_RD, 0, 1); expect_ev(K_RD, 1, 3); expect_ev(K_POOL, 0, 5);
      expect_ev(K_FC, 0, 9); expect_ev(K_DONE, 0, 12);
      run(0, 1'b0);
      // single conv layer
      clr();
      mem[0] = 1; mem[1] = 0; mem[2] = 5; mem[3] = 6; mem[4] = 6;
      expect_ev(K_RD, 0, 1); expect_ev(K_RD, 1, 3); expect_ev(K_RD, 2, 5);
      expect_ev(K_RD, 3, 7); expect_ev(K_RD, 4, 9);
      expect_ev(K_CONV, conv_val(0, 5, 6, 5, 11), 12);
      expect_ev(K_FC, 0, -1); expect_ev(K_DONE, 0, -1);
      run(0, 1'b0);
      // conv, pool, conv
      mem[0] = 3; mem[161] = 1; mem[162] = 0; mem[163] = 5; mem[164] = 96; mem[165] = 16;
      for (int a = 0; a < 5; a++) expect_ev(K_RD, a, -1);
      expect_ev(K_CONV, conv_val(0, 5, 6, 5, 11), -1);
      expect_ev(K_RD, 161, -1); expect_ev(K_POOL, 1, -1);
      for (int a = 162; a < 166; a++) expect_ev(K_RD, a, -1);
      expect_ev(K_CONV, conv_val(2, 5, 96, 166, 182), -1);
      expect_ev(K_FC, 0, -1); expect_ev(K_DONE, 0, -1);
      run(0, 1'b0);
      // zero layers
      clr();
      expect_ev(K_RD, 0, 1); expect_ev(K_FC, 0, 3); expect_ev(K_DONE, 0, -1);
      run(0, 1'b0);
      // bad type word, then restart out of ERR
      mem[0] = 1; mem[1] = 7;
      expect_ev(K_RD, 0, 1); expect_ev(K_RD, 1, 3);
      run(0, 1'b1);
      mem[1] = 1;
      expect_ev(K_RD, 0, 1); expect_ev(K_RD, 1, 3); expect_ev(K_POOL, 0, 5);
      expect_ev(K_FC, 0, 9); expect_ev(K_DONE, 0, 12);
      run(0, 1'b0);
      // oversize kernel
      clr();
      mem[0] = 1; mem[1] = 0; mem[2] = 9; mem[3] = 1; mem[4] = 1;
      for (int a = 0; a < 5; a++) expect_ev(K_RD, a, -1);
      run(0, 1'b1);
      // weight block runs past the end of the address space
      mem[2] = 7; mem[3] = 2000; mem[4] = 0;
      for (int a = 0; a < 5; a++) expect_ev(K_RD, a, -1);
      run(0, 1'b1);
      // start while busy is ignored
      clr();
      mem[0] = 1; mem[1] = 1;
      expect_ev(K_RD, 0, 1); expect_ev(K_RD, 1, 3); expect_ev(K_POOL, 0, 5);
      expect_ev(K_FC, 0, 9); expect_ev(K_DONE, 0, 12);
      run(2, 1'b0);
      // reset while waiting on the conv engine, then a stray conv_done
      mem[1] = 0; mem[2] = 5; mem[3] = 6; mem[4] = 6;
      eng_conv = 1'b0;
      for (int a = 0; a < 5; a++) expect_ev(K_RD, a, -1);
      expect_ev(K_CONV, conv_val(0, 5, 6, 5, 11), 12);
      t0 = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && !conv_start; i++) @(negedge clk);
      check("conv_start_seen", conv_start, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_reset_outputs", any_out, 0);
      force_cd = 1'b1;
      @(negedge clk);
      force_cd = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_done_outputs", any_out, 0);
      check("sb_after_reset", q.size(), 0);
      eng_conv = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
